// File: rtl/dequant_unit.sv
// Streaming dequantizer: out = sat((act * alpha[ch]) << beta[ch]) through a 3-stage elastic pipe.
// Optional saturation counter (sat_clr/sat_cnt) is built when DEQ_SAT_CNT_EN is defined.
module dequant_unit #(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned PSUM_WIDTH  = 32,
  parameter int unsigned ALPHA_WIDTH = 8,
  parameter int unsigned BETA_WIDTH  = 4,
  parameter int unsigned NUM_CH      = 16,
  parameter int unsigned CH_WIDTH    = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   cfg_we,
  input  logic [CH_WIDTH-1:0]    cfg_addr,
  input  logic [ALPHA_WIDTH-1:0] cfg_alpha,
  input  logic [BETA_WIDTH-1:0]  cfg_beta,
  input  logic [CH_WIDTH-1:0]    num_ch_m1,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [DATA_WIDTH-1:0]  in_data,
  input  logic                   in_last,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [PSUM_WIDTH-1:0]  out_data,
  output logic [CH_WIDTH-1:0]    out_ch,
  output logic                   out_last,
`ifdef DEQ_SAT_CNT_EN
  input  logic                   sat_clr,
  output logic [15:0]            sat_cnt,
`endif
  output logic                   out_sat
);

  localparam int unsigned ProdW = DATA_WIDTH + ALPHA_WIDTH;
  localparam int unsigned ShW   = ProdW + (1 << BETA_WIDTH) - 1;
  localparam int unsigned CmpW  = (ShW > PSUM_WIDTH) ? ShW : PSUM_WIDTH;
  localparam logic [CmpW-1:0] SatMax = CmpW'((64'd1 << (PSUM_WIDTH - 1)) - 64'd1);

  logic [ALPHA_WIDTH-1:0] alpha_q [NUM_CH];
  logic [BETA_WIDTH-1:0]  beta_q  [NUM_CH];

  logic [CH_WIDTH-1:0] ch_q, ch_d;

  logic                   s1_v_q, s1_v_d;
  logic [DATA_WIDTH-1:0]  s1_data_q;
  logic [ALPHA_WIDTH-1:0] s1_alpha_q;
  logic [BETA_WIDTH-1:0]  s1_beta_q;
  logic [CH_WIDTH-1:0]    s1_ch_q;
  logic                   s1_last_q;

  logic                   s2_v_q, s2_v_d;
  logic [ProdW-1:0]       s2_prod_q;
  logic [BETA_WIDTH-1:0]  s2_beta_q;
  logic [CH_WIDTH-1:0]    s2_ch_q;
  logic                   s2_last_q;

  logic                   s3_v_q, s3_v_d;

  logic accept, s2_load, s3_load;
  logic [CmpW-1:0]       shifted;
  logic                  sat_d;
  logic [PSUM_WIDTH-1:0] data_d;

  // A stage loads when its upstream holds a beat and it is empty or emptying this cycle.
  always_comb begin
    s3_load  = s2_v_q & (~s3_v_q | out_ready);
    s2_load  = s1_v_q & (~s2_v_q | s3_load);
    in_ready = ~s1_v_q | s2_load;
    accept   = in_valid & in_ready;
    s1_v_d   = accept | (s1_v_q & ~s2_load);
    s2_v_d   = s2_load | (s2_v_q & ~s3_load);
    s3_v_d   = s3_load | (s3_v_q & ~out_ready);
    ch_d     = ch_q;
    if (accept) begin
      ch_d = (in_last || ch_q >= num_ch_m1) ? '0 : ch_q + 1'b1;
    end
  end

  always_comb begin
    shifted = CmpW'(s2_prod_q) << s2_beta_q;
    sat_d   = shifted > SatMax;
    data_d  = sat_d ? SatMax[PSUM_WIDTH-1:0] : shifted[PSUM_WIDTH-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        alpha_q[i] <= ALPHA_WIDTH'(1);
        beta_q[i]  <= '0;
      end
    end else if (cfg_we) begin
      alpha_q[cfg_addr] <= cfg_alpha;
      beta_q[cfg_addr]  <= cfg_beta;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ch_q       <= '0;
      s1_v_q     <= 1'b0;
      s1_data_q  <= '0;
      s1_alpha_q <= '0;
      s1_beta_q  <= '0;
      s1_ch_q    <= '0;
      s1_last_q  <= 1'b0;
      s2_v_q     <= 1'b0;
      s2_prod_q  <= '0;
      s2_beta_q  <= '0;
      s2_ch_q    <= '0;
      s2_last_q  <= 1'b0;
      s3_v_q     <= 1'b0;
      out_data   <= '0;
      out_ch     <= '0;
      out_last   <= 1'b0;
      out_sat    <= 1'b0;
    end else begin
      ch_q   <= ch_d;
      s1_v_q <= s1_v_d;
      s2_v_q <= s2_v_d;
      s3_v_q <= s3_v_d;
      // Table read sees the pre-write value when cfg targets the same entry this cycle.
      if (accept) begin
        s1_data_q  <= in_data;
        s1_alpha_q <= alpha_q[ch_q];
        s1_beta_q  <= beta_q[ch_q];
        s1_ch_q    <= ch_q;
        s1_last_q  <= in_last;
      end
      if (s2_load) begin
        s2_prod_q <= ProdW'(s1_data_q) * ProdW'(s1_alpha_q);
        s2_beta_q <= s1_beta_q;
        s2_ch_q   <= s1_ch_q;
        s2_last_q <= s1_last_q;
      end
      if (s3_load) begin
        out_data <= data_d;
        out_ch   <= s2_ch_q;
        out_last <= s2_last_q;
        out_sat  <= sat_d;
      end
    end
  end

  assign out_valid = s3_v_q;

`ifdef DEQ_SAT_CNT_EN
  logic [15:0] sat_cnt_q, sat_cnt_d;

  always_comb begin
    sat_cnt_d = sat_cnt_q;
    if (sat_clr) begin
      sat_cnt_d = '0;
    end else if (s3_v_q && out_ready && out_sat && sat_cnt_q != 16'hFFFF) begin
      sat_cnt_d = sat_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sat_cnt_q <= '0;
    end else begin
      sat_cnt_q <= sat_cnt_d;
    end
  end

  assign sat_cnt = sat_cnt_q;
`endif

endmodule
